// File: rtl/xoodoo_sponge_if.sv
// Stream bundle for xoodoo_sponge: 32-bit message input and 32-bit digest output.
interface xoodoo_sponge_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [2:0]  in_nbytes;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  modport master (
    output in_valid, in_data, in_last, in_nbytes, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_nbytes, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/xoodoo_sponge.sv
// Sponge controller around the Xoodoo permutation: absorb, pad, permute, squeeze.
// Optional XOODOO_SPONGE_TIMEOUT_EN adds a PERM_WAIT watchdog and the perm_err port.
//
// state     | meaning
// IDLE      | S cleared, waiting for the first message word
// ABSORB    | XOR incoming words into the rate, apply padding on the last word
// PADBLK    | message ended exactly on a block boundary: pad-only block
// PREQ      | one-cycle perm_enable pulse
// PERM_WAIT | waiting for perm_done, then load S from the core
// SQUEEZE   | emit rate words of S as digest
module xoodoo_sponge #(
  parameter int RATE_WORDS = 4,
  parameter int OUT_WORDS  = 8
) (
  input  logic          clk,
  input  logic          resetn,
  xoodoo_sponge_if.slave stream,
  output logic          perm_enable,
  output logic [0:383]  perm_state,
  input  logic [0:383]  perm_state_out,
  input  logic          perm_done,
  output logic          busy
`ifdef XOODOO_SPONGE_TIMEOUT_EN
  ,
  output logic          perm_err
`endif
);

  typedef enum logic [2:0] {IDLE, ABSORB, PADBLK, PREQ, PERM_WAIT, SQUEEZE} state_t;
  typedef enum logic [1:0] {AFT_ABSORB, AFT_PADBLK, AFT_SQUEEZE} after_t;

  localparam logic [3:0] W_LAST  = 4'(RATE_WORDS - 1);
  localparam logic [6:0] D_LAST  = 7'(OUT_WORDS - 1);
  localparam int         DOM_BIT = 32 * (RATE_WORDS - 1) + 24;

  state_t       state, state_nxt;
  after_t       after, after_nxt;
  logic [0:383] s, s_nxt, absorb_x;
  logic [3:0]   w, w_nxt, r, r_nxt;
  logic [6:0]   d, d_nxt;
  logic [8:0]   w_base, w1_base, r_base;
  logic         live, accept, go_idle;

  function automatic logic [31:0] byte_mask(input logic [2:0] n);
    case (n)
      3'd0:    return 32'h0000_0000;
      3'd1:    return 32'hFF00_0000;
      3'd2:    return 32'hFFFF_0000;
      3'd3:    return 32'hFFFF_FF00;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] pad_byte(input logic [2:0] n);
    case (n)
      3'd0:    return 32'h0100_0000;
      3'd1:    return 32'h0001_0000;
      3'd2:    return 32'h0000_0100;
      3'd3:    return 32'h0000_0001;
      default: return 32'h0000_0000;
    endcase
  endfunction

  assign w_base  = {w, 5'd0};
  assign w1_base = {w + 4'd1, 5'd0};
  assign r_base  = {r, 5'd0};

  // in_ready is held low until the first clock after reset release
  assign stream.in_ready  = live && (state == IDLE || state == ABSORB);
  assign stream.out_valid = (state == SQUEEZE);
  assign stream.out_last  = (state == SQUEEZE) && (d == D_LAST);
  assign stream.out_data  = (state == SQUEEZE) ? s[r_base +: 32] : 32'h0;
  assign accept      = stream.in_valid && stream.in_ready;
  assign perm_enable = (state == PREQ);
  assign perm_state  = s;
  assign busy        = (state != IDLE);

`ifdef XOODOO_SPONGE_TIMEOUT_EN
  logic [5:0] wd_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_cnt   <= 6'd0;
      perm_err <= 1'b0;
    end else begin
      if (state == PREQ)
        wd_cnt <= 6'd62;
      else if (state == PERM_WAIT && wd_cnt != 6'd0)
        wd_cnt <= wd_cnt - 6'd1;
      if (state == PERM_WAIT && !perm_done && wd_cnt == 6'd0)
        perm_err <= 1'b1;
      else if (accept)
        perm_err <= 1'b0;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    after_nxt = after;
    s_nxt     = s;
    w_nxt     = w;
    r_nxt     = r;
    d_nxt     = d;
    absorb_x  = '0;
    go_idle   = 1'b0;
    case (state)
      IDLE, ABSORB: begin
        if (accept) begin
          absorb_x[w_base +: 32] = stream.in_data & byte_mask(stream.in_nbytes);
          if (stream.in_last) begin
            state_nxt = PREQ;
            after_nxt = AFT_SQUEEZE;
            if (stream.in_nbytes != 3'd4) begin
              absorb_x[w_base +: 32]  = absorb_x[w_base +: 32] ^ pad_byte(stream.in_nbytes);
              absorb_x[DOM_BIT +: 8] = absorb_x[DOM_BIT +: 8] ^ 8'h80;
            end else if (w == W_LAST) begin
              after_nxt = AFT_PADBLK;
            end else begin
              absorb_x[w1_base +: 8] = absorb_x[w1_base +: 8] ^ 8'h01;
              absorb_x[DOM_BIT +: 8] = absorb_x[DOM_BIT +: 8] ^ 8'h80;
            end
          end else if (w == W_LAST) begin
            state_nxt = PREQ;
            after_nxt = AFT_ABSORB;
          end else begin
            state_nxt = ABSORB;
            w_nxt     = w + 4'd1;
          end
          s_nxt = s ^ absorb_x;
        end
      end
      PADBLK: begin
        absorb_x[0 +: 8]        = 8'h01;
        absorb_x[DOM_BIT +: 8] = absorb_x[DOM_BIT +: 8] ^ 8'h80;
        s_nxt     = s ^ absorb_x;
        state_nxt = PREQ;
        after_nxt = AFT_SQUEEZE;
      end
      PREQ: state_nxt = PERM_WAIT;
      PERM_WAIT: begin
        if (perm_done) begin
          s_nxt = perm_state_out;
          case (after)
            AFT_ABSORB: begin state_nxt = ABSORB;  w_nxt = 4'd0; end
            AFT_PADBLK: state_nxt = PADBLK;
            default:    begin state_nxt = SQUEEZE; r_nxt = 4'd0; end
          endcase
        end
`ifdef XOODOO_SPONGE_TIMEOUT_EN
        else if (wd_cnt == 6'd0) begin
          go_idle = 1'b1;
        end
`endif
      end
      SQUEEZE: begin
        if (stream.out_ready) begin
          d_nxt = d + 7'd1;
          r_nxt = r + 4'd1;
          if (d == D_LAST) begin
            go_idle = 1'b1;
          end else if (r == W_LAST) begin
            state_nxt = PREQ;
            after_nxt = AFT_SQUEEZE;
          end
        end
      end
      default: go_idle = 1'b1;
    endcase
    if (go_idle) begin
      state_nxt = IDLE;
      s_nxt     = '0;
      w_nxt     = 4'd0;
      r_nxt     = 4'd0;
      d_nxt     = 7'd0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      after <= AFT_ABSORB;
      s     <= '0;
      w     <= 4'd0;
      r     <= 4'd0;
      d     <= 7'd0;
      live  <= 1'b0;
    end else begin
      state <= state_nxt;
      after <= after_nxt;
      s     <= s_nxt;
      w     <= w_nxt;
      r     <= r_nxt;
      d     <= d_nxt;
      live  <= 1'b1;
    end
  end

endmodule

// File: doc/xoodoo_sponge.md
# xoodoo_sponge

Sponge controller feeding the 384-bit Xoodoo permutation core. It absorbs a 32-bit message stream into the rate part of the state and applies padding and the domain bit. For each block it launches the permutation through the `enable_xoodoo` / `done_permutations` handshake, then squeezes a fixed-length digest as a 32-bit output stream. It sits directly upstream of the permutation core and consumes the state that core returns.

## Interface
- `RATE_WORDS`, 4: rate in 32-bit words (1..11); state words 0..RATE_WORDS-1 are rate.
- `OUT_WORDS`, 8: digest length in 32-bit words (1..64).
- `clk` input 1: clock.
- `resetn` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: input word valid.
- `in_ready` output 1: block accepts a word this cycle.
- `in_data` input 32: message word; `[31:24]` is the first byte.
- `in_last` input 1: final message word.
- `in_nbytes` input 3: valid bytes in the word, taken from the top byte down. Must be 4 when `in_last`=0. Range 0..4 when `in_last`=1.
- `perm_enable` output 1: one-cycle pulse to the core's `enable_xoodoo`.
- `perm_state` output 384 `[0:383]`: state to the core's `state_in`. Word k is `[32k:32k+31]`.
- `perm_state_out` input 384 `[0:383]`: the core's `state_out`.
- `perm_done` input 1: the core's `done_permutations`, a one-cycle pulse.
- `out_valid` output 1: digest word valid.
- `out_ready` input 1: consumer accepts the word.
- `out_data` output 32: digest word.
- `out_last` output 1: final digest word.
- `busy` output 1: FSM not in IDLE.

## Operation
- The state register S[0:383] drives `perm_state` continuously.
- FSM states and transitions:
  - IDLE: S=0, word index w=0, `in_ready`=1. The first accepted word moves to ABSORB and is processed as in ABSORB.
  - ABSORB: `in_ready`=1. Each accepted word does S[w] ^= word, with bytes beyond `in_nbytes` masked to 0. Then w++.
  - When w reaches RATE_WORDS on a non-last word, go to PREQ (block full). After PERM_WAIT, return to ABSORB with w=0.
  - Last word, `in_nbytes`<4: XOR pad byte 0x01 at byte position `in_nbytes` of that word. XOR 0x80 into the last rate byte, S[RATE_WORDS-1][7:0]. Go to PREQ, then SQUEEZE.
  - Last word, `in_nbytes`=4, rate not yet full: pad 0x01 goes at byte 0 of word w+1 and 0x80 at the last rate byte, in the same cycle.
  - Last word, `in_nbytes`=4, word fills the rate: go to PREQ with no padding. After PERM_WAIT, go to PADBLK.
  - PADBLK: S[0][31:24] ^= 0x01 and S[RATE_WORDS-1][7:0] ^= 0x80 in one cycle, then PREQ. Zero-length message: the `in_nbytes`=0 pad lands at word 0 byte 0.
  - If pad and domain bytes coincide (RATE_WORDS=1, `in_nbytes`=3), both XORs apply, giving byte value 0x81.
  - PREQ: `perm_enable`=1 for exactly one cycle, then PERM_WAIT.
  - PERM_WAIT: `in_ready`=0. On `perm_done`, S <= `perm_state_out` on that edge, then continue to the next state. `perm_done` seen outside PERM_WAIT is ignored.
  - SQUEEZE: `out_data`=S[r], r=0.. ; `out_valid`=1. On `out_valid`&&`out_ready`, r++ and digest counter d++.
  - In SQUEEZE, when d reaches OUT_WORDS: `out_last` was high on that word; go to IDLE.
  - In SQUEEZE, when r reaches RATE_WORDS with d<OUT_WORDS: PREQ, then SQUEEZE with r=0.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.
- `in_ready`=0 in every state except IDLE and ABSORB.

## Timing
- Reset values: `in_ready`=0 during reset (1 after release, in IDLE), `perm_enable`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0. S=0 and all counters 0.
- Asserting reset in any state aborts immediately and returns to IDLE. A subsequent `perm_done` is ignored.
- Absorb throughput: 1 word per cycle.
- Last absorbed word to `perm_enable`: 1 cycle. PADBLK adds 1 cycle.
- `perm_done` to first `out_valid`: 1 cycle.
- The core's latency (≈16 cycles) is not assumed; the block waits for `perm_done` indefinitely unless the timeout option is enabled.
- `perm_enable` falls before the core samples, satisfying the core's falling-edge start rule.

## Configuration
- `XOODOO_SPONGE_TIMEOUT_EN`, defined: a 6-bit watchdog counts cycles in PERM_WAIT. If 63 cycles pass without `perm_done`:
  - `perm_err` output (1 bit, reset 0) is set.
  - The FSM returns to IDLE.
  - `perm_err` clears on the next accepted input word.
- Undefined: no watchdog; the `perm_err` port is absent.

## Test plan
- Empty message (`in_last`=1, `in_nbytes`=0) -> at `perm_enable`, `perm_state` word0=0x01000000, word3=0x00000080, other words 0. Exactly 8 output words with `out_last` on word 8, and 2 `perm_enable` pulses in total.
- 3-byte message 0xAABBCC00, `in_nbytes`=3 -> word0=0xAABBCC01, word3=0x00000080 at the first `perm_enable`.
- 16-byte message (4 full words, last on word 4) -> two absorb permutations. The second `perm_state` equals the first `perm_state_out` XOR word0 0x01000000 and word3 0x00000080.
- `out_ready` held low 5 cycles mid-squeeze -> `out_data` unchanged and no words dropped or duplicated. Digest matches the reference model with the real permutation core.
- Reset asserted in PERM_WAIT -> all outputs at reset values. A late `perm_done` produces no output, and a new message hashes correctly.
- With `XOODOO_SPONGE_TIMEOUT_EN`, `perm_done` tied 0 -> `perm_err`=1 after 63 cycles in PERM_WAIT, `busy`=0.
